// File: rtl/mda_vram_fetch_if.sv
// CPU-side request/acknowledge bus into the MDA video RAM arbiter.
interface mda_vram_fetch_if #(
  parameter int VRAM_AW = 12
);
  logic               cpu_req;
  logic               cpu_we;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [7:0]         cpu_wdata;
  logic [7:0]         cpu_rdata;
  logic               cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/mda_vram_fetch.sv
// MDA video RAM timing master: 18-clock character sequence, video byte fetch
// and one CPU access slot per character.
module mda_vram_fetch #(
  parameter int VRAM_AW = 12,
  parameter int MA_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MA_W-1:0]    ma,
  output logic               crtc_clk,
  output logic [4:0]         clk_seq,
  output logic [7:0]         vram_data,
  output logic               vram_read_char,
  output logic               vram_read_att,
  output logic               charrom_read,
  output logic               disp_pipeline,
  output logic [VRAM_AW-1:0] ram_a,
  input  logic [7:0]         ram_din,
  output logic [7:0]         ram_dout,
  output logic               ram_oe,
  output logic               ram_we,
  mda_vram_fetch_if.slave    cpu
);

  localparam logic [4:0] SEQ_LAST = 5'd17;

  typedef enum logic [1:0] {CPU_IDLE, CPU_RD, CPU_WR} cpu_st_t;

  cpu_st_t            r_st, w_st_nxt;
  logic [4:0]         r_seq, w_seq_nxt;
  logic [MA_W-1:0]    r_ma_q, w_ma_src;
  logic [VRAM_AW-1:0] r_cpu_addr, w_addr_src;
  logic [VRAM_AW-1:0] r_ram_a, w_ram_a_nxt;
  logic               r_ram_oe, w_ram_oe_nxt;
  logic               r_ram_we;
  logic [7:0]         r_ram_dout, r_vram_data, r_cpu_rdata;
  logic               r_cpu_ack;
  logic               r_crtc, r_rd_char, r_rd_att, r_crom, r_disp;

  assign w_seq_nxt  = (r_seq == SEQ_LAST) ? 5'd0 : r_seq + 5'd1;
  // The registered address for slots 1 and 9 is formed in slots 0 and 8,
  // before ma / cpu_addr have landed in their holding registers.
  assign w_ma_src   = (r_seq == 5'd0) ? ma : r_ma_q;
  assign w_addr_src = (r_st == CPU_IDLE) ? cpu.cpu_addr : r_cpu_addr;

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      CPU_IDLE: if (r_seq == 5'd8 && cpu.cpu_req)
                  w_st_nxt = cpu.cpu_we ? CPU_WR : CPU_RD;
      default:  if (r_seq == 5'd11)
                  w_st_nxt = CPU_IDLE;
    endcase
  end

  always_comb begin
    w_ram_a_nxt  = {r_ma_q, 1'b1};
    w_ram_oe_nxt = 1'b1;
    if (w_seq_nxt >= 5'd1 && w_seq_nxt <= 5'd3) begin
      w_ram_a_nxt = {w_ma_src, 1'b0};
    end else if (w_st_nxt != CPU_IDLE) begin
      w_ram_a_nxt  = w_addr_src;
      w_ram_oe_nxt = (w_st_nxt == CPU_RD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st        <= CPU_IDLE;
      r_seq       <= 5'd0;
      r_ma_q      <= '0;
      r_cpu_addr  <= '0;
      r_ram_a     <= '0;
      r_ram_oe    <= 1'b1;
      r_ram_we    <= 1'b0;
      r_ram_dout  <= 8'h00;
      r_vram_data <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_cpu_ack   <= 1'b0;
      r_crtc      <= 1'b0;
      r_rd_char   <= 1'b0;
      r_rd_att    <= 1'b0;
      r_crom      <= 1'b0;
      r_disp      <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_seq     <= w_seq_nxt;
      r_ram_a   <= w_ram_a_nxt;
      r_ram_oe  <= w_ram_oe_nxt;
      r_ram_we  <= (r_st == CPU_WR) && (r_seq == 5'd9);
      r_cpu_ack <= (r_st != CPU_IDLE) && (r_seq == 5'd11);
      r_crtc    <= (w_seq_nxt == 5'd0);
      r_rd_char <= (w_seq_nxt == 5'd4);
      r_rd_att  <= (w_seq_nxt == 5'd7);
      r_crom    <= (w_seq_nxt == 5'd9);
      r_disp    <= (w_seq_nxt == SEQ_LAST);
      if (r_seq == 5'd0)
        r_ma_q <= ma;
      if (r_st == CPU_IDLE && w_st_nxt != CPU_IDLE)
        r_cpu_addr <= cpu.cpu_addr;
      if (r_st == CPU_IDLE && w_st_nxt == CPU_WR)
        r_ram_dout <= cpu.cpu_wdata;
      if (r_seq == 5'd3 || r_seq == 5'd6)
        r_vram_data <= ram_din;
      if (r_st == CPU_RD && r_seq == 5'd11)
        r_cpu_rdata <= ram_din;
    end
  end

  assign clk_seq        = r_seq;
  assign crtc_clk       = r_crtc;
  assign vram_read_char = r_rd_char;
  assign vram_read_att  = r_rd_att;
  assign charrom_read   = r_crom;
  assign disp_pipeline  = r_disp;
  assign vram_data      = r_vram_data;
  assign ram_a          = r_ram_a;
  assign ram_oe         = r_ram_oe;
  assign ram_we         = r_ram_we;
  assign ram_dout       = r_ram_dout;
  assign cpu.cpu_rdata  = r_cpu_rdata;
  assign cpu.cpu_ack    = r_cpu_ack;

endmodule

// File: tb/tb_mda_vram_fetch.sv
// Directed bench for mda_vram_fetch: video sequence, CPU read/write slot,
// late and held requests, and reset during a pending write.
module tb_mda_vram_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ma = 11'h123;
  logic        crtc_clk;
  logic [4:0]  clk_seq;
  logic [7:0]  vram_data;
  logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline;
  logic [11:0] ram_a;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_oe, ram_we;

  int n_pass = 0;
  int n_tot  = 0;

  mda_vram_fetch_if #(.VRAM_AW(12)) cpu_if ();

  mda_vram_fetch #(.VRAM_AW(12), .MA_W(11)) dut (
    .clk(clk), .reset(reset), .ma(ma),
    .crtc_clk(crtc_clk), .clk_seq(clk_seq), .vram_data(vram_data),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
    .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_oe(ram_oe), .ram_we(ram_we), .cpu(cpu_if)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: returns the low address byte, except 0xABC reads 0x5A.
  assign ram_din = (ram_a == 12'hABC) ? 8'h5A : ram_a[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_slot(input logic [4:0] n);
    int k = 0;
    @(negedge clk);
    while (clk_seq !== n && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("slot_reach", clk_seq, n);
  endtask

  initial begin
    int c_crtc, c_char, c_att, c_crom, c_disp, crtc_pos, acks, wes, ack_pos, lat;
    cpu_if.cpu_req = 1'b0;
    cpu_if.cpu_we = 1'b0;
    cpu_if.cpu_addr = 12'h000;
    cpu_if.cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_seq", clk_seq, 0);
    chk("rst_crtc", crtc_clk, 0);
    chk("rst_oe", ram_oe, 1);
    chk("rst_a", ram_a, 0);
    chk("rst_vdata", vram_data, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_ack", cpu_if.cpu_ack, 0);
    chk("rst_rdata", cpu_if.cpu_rdata, 0);
    chk("rst_dout", ram_dout, 0);
    reset = 1'b0;

    // First character after release: video fetch of cell 0x123.
    wait_slot(1);  chk("s1_a", ram_a, 12'h246); chk("s1_oe", ram_oe, 1);
    wait_slot(3);  chk("s3_a", ram_a, 12'h246);
    wait_slot(4);  chk("s4_char", vram_read_char, 1); chk("s4_vdata", vram_data, 8'h46);
                   chk("s4_a", ram_a, 12'h247);
    wait_slot(6);  chk("s6_a", ram_a, 12'h247);
    wait_slot(7);  chk("s7_att", vram_read_att, 1); chk("s7_vdata", vram_data, 8'h47);
                   chk("s7_char", vram_read_char, 0);
    wait_slot(9);  chk("s9_crom", charrom_read, 1);
    wait_slot(17); chk("s17_disp", disp_pipeline, 1);
    wait_slot(0);  chk("s0_crtc", crtc_clk, 1);

    c_crtc = 0; c_char = 0; c_att = 0; c_crom = 0; c_disp = 0; crtc_pos = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (crtc_clk) begin c_crtc++; crtc_pos = i + 1; end
      if (vram_read_char) c_char++;
      if (vram_read_att) c_att++;
      if (charrom_read) c_crom++;
      if (disp_pipeline) c_disp++;
    end
    chk("cnt_crtc", c_crtc, 1); chk("crtc_period", crtc_pos, 18);
    chk("cnt_char", c_char, 1); chk("cnt_att", c_att, 1);
    chk("cnt_crom", c_crom, 1); chk("cnt_disp", c_disp, 1);

    // CPU read of 0xABC.
    wait_slot(5);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 12'hABC;
    wait_slot(9);  chk("rd9_a", ram_a, 12'hABC); chk("rd9_oe", ram_oe, 1);
                   chk("rd9_crom", charrom_read, 1);
    wait_slot(10); chk("rd10_a", ram_a, 12'hABC); chk("rd10_we", ram_we, 0);
    wait_slot(11); chk("rd11_a", ram_a, 12'hABC); chk("rd11_ack", cpu_if.cpu_ack, 0);
    wait_slot(12); chk("rd12_ack", cpu_if.cpu_ack, 1); chk("rd12_rdata", cpu_if.cpu_rdata, 8'h5A);
                   chk("rd12_a", ram_a, 12'h247); chk("rd12_vdata", vram_data, 8'h47);
    cpu_if.cpu_req = 1'b0;
    wait_slot(13); chk("rd13_ack", cpu_if.cpu_ack, 0);

    // CPU write of 0xC3 to 0x010.
    wait_slot(5);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 12'h010; cpu_if.cpu_wdata = 8'hC3;
    wait_slot(9);  chk("wr9_oe", ram_oe, 0); chk("wr9_a", ram_a, 12'h010);
                   chk("wr9_dout", ram_dout, 8'hC3); chk("wr9_we", ram_we, 0);
    wait_slot(10); chk("wr10_we", ram_we, 1); chk("wr10_oe", ram_oe, 0);
                   chk("wr10_a", ram_a, 12'h010); chk("wr10_dout", ram_dout, 8'hC3);
    wait_slot(11); chk("wr11_we", ram_we, 0); chk("wr11_a", ram_a, 12'h010);
    wait_slot(12); chk("wr12_ack", cpu_if.cpu_ack, 1); chk("wr12_rdata", cpu_if.cpu_rdata, 8'h5A);
                   chk("wr12_oe", ram_oe, 1);
    cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0;

    // Request rising in slot 9 waits for the next character.
    wait_slot(9);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = 12'h0AA;
    wait_slot(10); chk("late10_a", ram_a, 12'h247);
    wait_slot(12); chk("late12_ack", cpu_if.cpu_ack, 0);
    wait_slot(0);
    lat = 0;
    while (!cpu_if.cpu_ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("late_latency", lat, 12);
    chk("late_rdata", cpu_if.cpu_rdata, 8'hAA);
    cpu_if.cpu_req = 1'b0;

    // Request held across two characters: one ack per character.
    wait_slot(13);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = 12'h055;
    wait_slot(0);
    for (int c = 0; c < 2; c++) begin
      acks = 0;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        if (cpu_if.cpu_ack) acks++;
      end
      chk(c == 0 ? "held_acks_c0" : "held_acks_c1", acks, 1);
    end
    cpu_if.cpu_req = 1'b0;

    // Reset in slot 10 of a pending write.
    wait_slot(5);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 12'h020; cpu_if.cpu_wdata = 8'h99;
    wait_slot(10); chk("prerst_we", ram_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_we", ram_we, 0); chk("arst_seq", clk_seq, 0);
    chk("arst_oe", ram_oe, 1); chk("arst_a", ram_a, 0); chk("arst_dout", ram_dout, 0);
    @(negedge clk);
    chk("arst_ack", cpu_if.cpu_ack, 0);
    reset = 1'b0;
    acks = 0; wes = 0; ack_pos = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (ram_we) wes++;
      if (cpu_if.cpu_ack) begin
        acks++;
        ack_pos = i + 1;
        cpu_if.cpu_req = 1'b0;
      end
    end
    chk("post_rst_acks", acks, 1);
    chk("post_rst_ack_slot", ack_pos, 12);
    chk("post_rst_wes", wes, 1);
    acks = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (cpu_if.cpu_ack) acks++;
    end
    chk("post_rst_no_dup", acks, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
